// File: rtl/fifo_ptr_ctrl_if.sv
// Handshake and status bundle between a FIFO requester and fifo_ptr_ctrl.
//   master : drives clr / wr_en / rd_en, observes RAM controls, flags, count, Gray pointers
//   slave  : the pointer controller side
interface fifo_ptr_ctrl_if #(
    parameter int unsigned C_ADDR_WIDTH = 4
);
    logic                    clr;
    logic                    wr_en;
    logic                    rd_en;
    logic                    ram_we;
    logic                    ram_re;
    logic [C_ADDR_WIDTH-1:0] wr_addr;
    logic [C_ADDR_WIDTH-1:0] rd_addr;
    logic                    full;
    logic                    empty;
    logic                    almost_full;
    logic                    almost_empty;
    logic [C_ADDR_WIDTH:0]   data_count;
    logic [C_ADDR_WIDTH:0]   wr_ptr_gray;
    logic [C_ADDR_WIDTH:0]   rd_ptr_gray;
    logic                    overflow;
    logic                    underflow;

    modport master (
        output clr, wr_en, rd_en,
        input  ram_we, ram_re, wr_addr, rd_addr,
        input  full, empty, almost_full, almost_empty, data_count,
        input  wr_ptr_gray, rd_ptr_gray, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, rd_en,
        output ram_we, ram_re, wr_addr, rd_addr,
        output full, empty, almost_full, almost_empty, data_count,
        output wr_ptr_gray, rd_ptr_gray, overflow, underflow
    );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Single-clock FIFO pointer/flag controller for an external simple dual-port line RAM.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : fifo_ptr_ctrl_if.slave -- clr/wr_en/rd_en in; RAM enables/addresses (combinational),
//            registered flags, occupancy, Gray pointers and overflow/underflow pulses out
module fifo_ptr_ctrl #(
    parameter int unsigned C_ADDR_WIDTH    = 4,
    parameter int unsigned C_AFULL_THRESH  = 12,
    parameter int unsigned C_AEMPTY_THRESH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    fifo_ptr_ctrl_if.slave  bus
);
    localparam int unsigned PW    = C_ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << C_ADDR_WIDTH;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q,  count_d;
    logic [PW-1:0] wr_gray_q, wr_gray_d;
    logic [PW-1:0] rd_gray_q, rd_gray_d;
    logic          full_q,   full_d;
    logic          empty_q,  empty_d;
    logic          afull_q,  afull_d;
    logic          aempty_q, aempty_d;
    logic          ovf_q,    ovf_d;
    logic          unf_q,    unf_d;
    logic          wr_acc;
    logic          rd_acc;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    // Accept decisions use registered flags only, so there is no fall-through path
    assign wr_acc = bus.wr_en & ~full_q;
    assign rd_acc = bus.rd_en & ~empty_q;

    assign bus.ram_we  = wr_acc;
    assign bus.ram_re  = rd_acc;
    assign bus.wr_addr = wr_ptr_q[C_ADDR_WIDTH-1:0];
    assign bus.rd_addr = rd_ptr_q[C_ADDR_WIDTH-1:0];

    // Next-state: flags and Gray copies derive from next pointers so they move with them
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(wr_acc);
        rd_ptr_d = rd_ptr_q + PW'(rd_acc);
        count_d  = count_q + PW'(wr_acc) - PW'(rd_acc);
        ovf_d    = bus.wr_en & full_q;
        unf_d    = bus.rd_en & empty_q;

        // Flush wins over any same-cycle request
        if (bus.clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end

        wr_gray_d = bin2gray(wr_ptr_d);
        rd_gray_d = bin2gray(rd_ptr_d);
        full_d    = (count_d == PW'(DEPTH));
        empty_d   = (count_d == '0);
        afull_d   = (count_d >= PW'(C_AFULL_THRESH));
        aempty_d  = (count_d <= PW'(C_AEMPTY_THRESH));
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wr_gray_q <= '0;
            rd_gray_q <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wr_gray_q <= wr_gray_d;
            rd_gray_q <= rd_gray_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.data_count   = count_q;
    assign bus.wr_ptr_gray  = wr_gray_q;
    assign bus.rd_ptr_gray  = rd_gray_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed and model-checked bench for fifo_ptr_ctrl (depth 16, thresholds 12 / 2).
module tb_fifo_ptr_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    fifo_ptr_ctrl_if #(.C_ADDR_WIDTH(4)) bus ();

    fifo_ptr_ctrl #(
        .C_ADDR_WIDTH(4),
        .C_AFULL_THRESH(12),
        .C_AEMPTY_THRESH(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input int cnt);
        chk({tag, "_count"},  32'(bus.data_count),   32'(cnt));
        chk({tag, "_full"},   32'(bus.full),         32'(cnt == 16));
        chk({tag, "_empty"},  32'(bus.empty),        32'(cnt == 0));
        chk({tag, "_afull"},  32'(bus.almost_full),  32'(cnt >= 12));
        chk({tag, "_aempty"}, 32'(bus.almost_empty), 32'(cnt <= 2));
    endtask

    initial begin
        int          mcnt;
        logic [4:0]  mwp, mrp, pwg, prg;
        logic        w, r, c, wacc, racc, eovf, eunf;

        // Reset held two cycles with both requests active
        rst_n = 1'b0; bus.clr = 1'b0; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
        step(); step();
        chk_flags("reset", 0);
        chk("reset_wgray", 32'(bus.wr_ptr_gray), 32'd0);
        chk("reset_rgray", 32'(bus.rd_ptr_gray), 32'd0);
        chk("reset_ovf",   32'(bus.overflow),    32'd0);
        chk("reset_unf",   32'(bus.underflow),   32'd0);
        chk("reset_ram_re", 32'(bus.ram_re),     32'd0);
        rst_n = 1'b1; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        step();
        chk_flags("idle", 0);

        // Fill: 16 writes
        for (int i = 1; i <= 16; i++) begin
            bus.wr_en = 1'b1;
            #1;
            chk("fill_we",   32'(bus.ram_we),  32'd1);
            chk("fill_addr", 32'(bus.wr_addr), 32'(i - 1));
            step();
            chk_flags("fill", i);
            if (i == 5) chk("gray5", 32'(bus.wr_ptr_gray), 32'b00111);
        end
        chk("full_wgray", 32'(bus.wr_ptr_gray), 32'b11000);
        chk("full_waddr", 32'(bus.wr_addr),     32'd0);
        chk("full_noovf", 32'(bus.overflow),    32'd0);
        #1;
        chk("ovf_we", 32'(bus.ram_we), 32'd0);
        step();
        chk("ovf_pulse", 32'(bus.overflow), 32'd1);
        chk_flags("ovf", 16);
        bus.wr_en = 1'b0;
        step();
        chk("ovf_end", 32'(bus.overflow), 32'd0);

        // Drain: 16 reads
        for (int i = 1; i <= 16; i++) begin
            bus.rd_en = 1'b1;
            #1;
            chk("drain_re",   32'(bus.ram_re),  32'd1);
            chk("drain_addr", 32'(bus.rd_addr), 32'(i - 1));
            step();
            chk_flags("drain", 16 - i);
        end
        chk("empty_rgray", 32'(bus.rd_ptr_gray), 32'b11000);
        #1;
        chk("unf_re", 32'(bus.ram_re), 32'd0);
        step();
        chk("unf_pulse", 32'(bus.underflow), 32'd1);
        chk_flags("unf", 0);
        bus.rd_en = 1'b0;
        step();
        chk("unf_end", 32'(bus.underflow), 32'd0);

        // Simultaneous traffic at count 8
        bus.wr_en = 1'b1;
        repeat (8) step();
        chk_flags("to8", 8);
        bus.rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_flags("both8", 8);
        end
        bus.rd_en = 1'b0;
        repeat (8) step();
        chk_flags("refill", 16);
        bus.rd_en = 1'b1;
        step();
        chk_flags("both_full", 15);
        chk("both_full_ovf", 32'(bus.overflow), 32'd1);
        bus.wr_en = 1'b0;
        repeat (15) step();
        chk_flags("redrain", 0);
        bus.wr_en = 1'b1;
        step();
        chk_flags("both_empty", 1);
        chk("both_empty_unf", 32'(bus.underflow), 32'd1);
        chk("both_empty_ovf", 32'(bus.overflow),  32'd0);

        // Mid-operation reset discards contents
        bus.wr_en = 1'b1; bus.rd_en = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        chk_flags("midreset", 0);
        chk("midreset_wgray", 32'(bus.wr_ptr_gray), 32'd0);
        rst_n = 1'b1; bus.wr_en = 1'b0;
        step();

        // Random traffic against a reference model, clr pulsed mid-run
        mcnt = 0; mwp = '0; mrp = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc < 70) begin
                w = ($urandom_range(0, 9) < 8); r = ($urandom_range(0, 9) < 3);
            end else if (cyc < 110) begin
                w = ($urandom_range(0, 9) < 3); r = ($urandom_range(0, 9) < 8);
            end else begin
                w = ($urandom_range(0, 1) == 1); r = ($urandom_range(0, 1) == 1);
            end
            c = (cyc == 60) || (cyc == 150);
            if (c) begin w = 1'b1; r = 1'b1; end
            bus.wr_en = w; bus.rd_en = r; bus.clr = c;
            wacc = w & (mcnt != 16);
            racc = r & (mcnt != 0);
            eovf = w & (mcnt == 16) & ~c;
            eunf = r & (mcnt == 0) & ~c;
            #1;
            chk("rnd_we", 32'(bus.ram_we), 32'(wacc));
            chk("rnd_re", 32'(bus.ram_re), 32'(racc));
            pwg = bus.wr_ptr_gray; prg = bus.rd_ptr_gray;
            step();
            if (c) begin
                mcnt = 0; mwp = '0; mrp = '0;
            end else begin
                mcnt = mcnt + int'(wacc) - int'(racc);
                mwp  = mwp + 5'(wacc);
                mrp  = mrp + 5'(racc);
                chk("rnd_wgray_1bit", 32'($countones(pwg ^ bus.wr_ptr_gray)), 32'(wacc));
                chk("rnd_rgray_1bit", 32'($countones(prg ^ bus.rd_ptr_gray)), 32'(racc));
            end
            chk_flags("rnd", mcnt);
            chk("rnd_wgray", 32'(bus.wr_ptr_gray), 32'(mwp ^ (mwp >> 1)));
            chk("rnd_rgray", 32'(bus.rd_ptr_gray), 32'(mrp ^ (mrp >> 1)));
            chk("rnd_ovf",   32'(bus.overflow),    32'(eovf));
            chk("rnd_unf",   32'(bus.underflow),   32'(eunf));
        end
        bus.clr = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
